// File: rtl/multi_sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared constants, types and helpers for the multi-channel synchroniser.
//   SYNC_STAGES_DEF      default synchroniser depth
//   DEBOUNCE_CYCLES_BTN  stability window used for push-buttons
//                        (10 ms at a 50 MHz system clock)
//   ch_out_t             per-channel registered outputs (level + edge pulses)
//   cnt_width()          width of the stability counter for a given window
// -----------------------------------------------------------------------------
package sync_pkg;

  localparam int SYNC_STAGES_DEF              = 32'sd2;
  localparam int unsigned DEBOUNCE_CYCLES_BTN = 32'd500_000;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } ch_out_t;

  // Counter width able to hold 0..filt_cycles; never narrower than one bit.
  function automatic int cnt_width(input int filt_cycles);
    int w;
    w = $clog2(filt_cycles + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/multi_sync_filter_if.sv
// -----------------------------------------------------------------------------
// multi_sync_filter_if
// Bundles the asynchronous inputs and the synchronised outputs of the
// synchroniser.
//   async_in  WIDTH  asynchronous inputs (driven by master)
//   sync_out  WIDTH  synchronised, filtered level (driven by slave)
//   rise_out  WIDTH  one-cycle 0->1 pulse on sync_out (driven by slave)
//   fall_out  WIDTH  one-cycle 1->0 pulse on sync_out (driven by slave)
// -----------------------------------------------------------------------------
interface multi_sync_filter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_out,
    input  fall_out
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_out,
    output fall_out
  );
endinterface

// File: rtl/multi_sync_filter_ch.sv
// -----------------------------------------------------------------------------
// sync_filter_ch
// One synchroniser channel: STAGES-deep sync chain, stability filter requiring
// FILT_CYCLES consecutive cycles of a new level, registered rise/fall pulses.
//   clk      system clock
//   rst      synchronous, active-high reset
//   async_i  asynchronous input bit
//   out_o    registered level, rise pulse, fall pulse
// -----------------------------------------------------------------------------
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES      = SYNC_STAGES_DEF,
  parameter int   FILT_CYCLES = 1,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    async_i,
  output ch_out_t out_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_ch: STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("sync_filter_ch: FILT_CYCLES must be >= 1");
  end

  localparam int CNT_W = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [STAGES-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              s_s;

  assign s_s = stage_q[STAGES-1];

  // Next-state: shift the sync chain, count how long s has differed from the
  // output level and commit the new level once the window is complete.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], async_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s_s == level_q) begin
      // Any return to the current level discards a partial window.
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      level_d = s_s;
      cnt_d   = {CNT_W{1'b0}};
      rise_d  = s_s;
      fall_d  = ~s_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset wins over any pending filter window.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {STAGES{RESET_BIT}};
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out_o.level = level_q;
  assign out_o.rise  = rise_q;
  assign out_o.fall  = fall_q;

endmodule

// File: rtl/multi_sync_filter.sv
// -----------------------------------------------------------------------------
// multi_sync_filter
// WIDTH independent synchroniser/debounce channels with edge pulses.
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   slave side of multi_sync_filter_if:
//           async_in (in), sync_out / rise_out / fall_out (out, registered)
// Parameters: WIDTH, STAGES, FILT_CYCLES, RESET_VAL (per-channel reset level).
// -----------------------------------------------------------------------------
module multi_sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = SYNC_STAGES_DEF,
  parameter int               FILT_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input logic                clk,
  input logic                rst,
  multi_sync_filter_if.slave bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("multi_sync_filter: WIDTH must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ch_out_t ch_s;

    sync_filter_ch #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_BIT   (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.async_in[i]),
      .out_o   (ch_s)
    );

    assign bus.sync_out[i] = ch_s.level;
    assign bus.rise_out[i] = ch_s.rise;
    assign bus.fall_out[i] = ch_s.fall;
  end

endmodule

// File: tb/tb_multi_sync_filter.sv
module tb_multi_sync_filter;

  localparam int NCYC = 3000;
  localparam int A_W  = 8;
  localparam int A_ST = 3;
  localparam int A_FC = 3;
  localparam logic [A_W-1:0] A_RV = 8'hA5;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  multi_sync_filter_if #(.WIDTH(A_W)) bus_a ();
  multi_sync_filter_if #(.WIDTH(1))   bus_b ();

  multi_sync_filter #(
    .WIDTH(A_W), .STAGES(A_ST), .FILT_CYCLES(A_FC), .RESET_VAL(A_RV)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );

  multi_sync_filter dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [A_W-1:0] lvl;
    logic [A_W-1:0] rise;
    logic [A_W-1:0] fall;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: input seen STAGES edges late (delay line), output flips after the
  // delayed level has differed from it for FILT consecutive edges.
  logic [A_W-1:0] m_dly[$];
  logic [A_W-1:0] m_out;
  int             m_run[A_W];

  function automatic exp_t model_edge(input logic r, input logic [A_W-1:0] in_v);
    exp_t e;
    logic [A_W-1:0] s;
    e.rise = '0;
    e.fall = '0;
    if (r) begin
      m_dly.delete();
      for (int k = 0; k < A_ST; k++) m_dly.push_back(A_RV);
      m_out = A_RV;
      for (int i = 0; i < A_W; i++) m_run[i] = 0;
    end else begin
      s = m_dly[0];
      for (int i = 0; i < A_W; i++) begin
        if (s[i] == m_out[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] + 1 >= A_FC) begin
          m_out[i]  = s[i];
          m_run[i]  = 0;
          e.rise[i] = s[i];
          e.fall[i] = ~s[i];
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end
      void'(m_dly.pop_front());
      m_dly.push_back(in_v);
    end
    e.lvl = m_out;
    return e;
  endfunction

  initial begin
    logic [A_W-1:0] cur_in;
    logic           cur_rst;
    int             hold[A_W];
    exp_t           e;
    checks = 0;
    errors = 0;
    rst_b  = 1'b1;
    bus_b.async_in = 1'b0;
    cur_rst = 1'b1;
    cur_in  = 8'($urandom);
    for (int i = 0; i < A_W; i++) hold[i] = 0;
    rst_a = cur_rst;
    bus_a.async_in = cur_in;

    fork
      // Random driver + reference model for dut_a.
      begin
        for (int c = 0; c < NCYC; c++) begin
          @(posedge clk);
          exp_q.push_back(model_edge(cur_rst, cur_in));
          #1;
          cur_rst = (c < 2) || ($urandom_range(0, 199) == 0);
          for (int i = 0; i < A_W; i++) begin
            if (hold[i] == 0) begin
              cur_in[i] = ~cur_in[i];
              hold[i]   = $urandom_range(1, 6);
            end else begin
              hold[i] = hold[i] - 1;
            end
          end
          rst_a = cur_rst;
          bus_a.async_in = cur_in;
        end
      end
      // Monitor / scoreboard for dut_a.
      begin
        for (int c = 0; c < NCYC; c++) begin
          @(negedge clk);
          if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("a_sync", 32'(bus_a.sync_out), 32'(e.lvl));
            check("a_rise", 32'(bus_a.rise_out), 32'(e.rise));
            check("a_fall", 32'(bus_a.fall_out), 32'(e.fall));
            check("a_rise_and_fall", 32'(bus_a.rise_out & bus_a.fall_out), 32'd0);
          end
        end
      end
      // Directed latency test on default-parameter dut_b.
      begin
        int edge_n;
        edge_n = 0;
        while (edge_n < 16) begin
          @(posedge clk);
          edge_n++;
          #1;
          if (edge_n == 2) rst_b = 1'b0;
          if (edge_n == 5) bus_b.async_in = 1'b1;
          if (edge_n == 10) bus_b.async_in = 1'b0;
          @(negedge clk);
          case (edge_n)
            2: begin
              check("b_rst_sync", 32'(bus_b.sync_out), 32'd0);
              check("b_rst_rise", 32'(bus_b.rise_out), 32'd0);
            end
            7: check("b_e7_sync", 32'(bus_b.sync_out), 32'd0);
            8: begin
              check("b_e8_sync", 32'(bus_b.sync_out), 32'd1);
              check("b_e8_rise", 32'(bus_b.rise_out), 32'd1);
            end
            9: begin
              check("b_e9_rise", 32'(bus_b.rise_out), 32'd0);
              check("b_e9_sync", 32'(bus_b.sync_out), 32'd1);
            end
            12: check("b_e12_sync", 32'(bus_b.sync_out), 32'd1);
            13: begin
              check("b_e13_sync", 32'(bus_b.sync_out), 32'd0);
              check("b_e13_fall", 32'(bus_b.fall_out), 32'd1);
            end
            14: check("b_e14_fall", 32'(bus_b.fall_out), 32'd0);
            default: ;
          endcase
        end
      end
    join

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
